// File: rtl/seq_frame_detector_pkg.sv
// Shared types and helpers for the serial frame detector.
package seq_frame_detector_pkg;

  // Framer state: hunting for sync, or deserialising payload bits.
  typedef enum logic {
    ST_HUNT    = 1'b0,
    ST_CAPTURE = 1'b1
  } state_t;

  // Counter width able to index n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_sync_matcher.sv
// Sync hunter: history shift register, fill counter and pattern compare.
// The pattern compare includes the bit arriving this cycle, so match is
// asserted combinationally on the cycle of the last sync bit.
module seq_sync_matcher #(
  parameter int                    SYNC_LEN = 4,
  parameter logic [SYNC_LEN-1:0]   SYNC_PAT = 4'b1011
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  input  logic Xin,
  output logic match
);

  localparam int FILL_W = $clog2(SYNC_LEN + 1);

  // Only the SYNC_LEN-1 most recent bits are needed; Xin supplies the last.
  logic [SYNC_LEN-2:0] sh;
  logic [FILL_W-1:0]   fill;

  // History shifts on every qualified bit; no flush on mismatch so
  // overlapping prefixes are still found.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh   <= '0;
      fill <= '0;
    end else if (clear) begin
      sh   <= '0;
      fill <= '0;
    end else if (en) begin
      sh <= (SYNC_LEN-1)'({sh, Xin});
      if (fill != FILL_W'(SYNC_LEN))
        fill <= fill + FILL_W'(1);
    end
  end

  assign match = en && (fill >= FILL_W'(SYNC_LEN - 1)) && ({sh, Xin} == SYNC_PAT);

endmodule

// File: rtl/seq_frame_detector.sv
// Serial framer: finds the sync pattern, then deserialises one payload word
// with a valid pulse, and counts captured frames (saturating).
module seq_frame_detector
  import seq_frame_detector_pkg::*;
#(
  parameter int                  SYNC_LEN    = 4,
  parameter logic [SYNC_LEN-1:0] SYNC_PAT    = 4'b1011,
  parameter int                  PAYLOAD_LEN = 8,
  parameter int                  CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   Xin,
  input  logic                   en,
  output logic [PAYLOAD_LEN-1:0] Data,
  output logic                   Valid,
  output logic                   SyncDet,
  output logic                   Locked,
  output logic [CNT_W-1:0]       FrameCnt
);

  localparam int BC_W = idx_w(PAYLOAD_LEN);

  state_t               state, state_nxt;
  logic [BC_W-1:0]      bitcnt;
  logic [PAYLOAD_LEN-1:0] pay;
  logic                 match;
  logic                 hunt_en;
  logic                 frame_done;

  // The matcher only sees bits while hunting, so payload is never re-detected.
  assign hunt_en    = en && (state == ST_HUNT);
  assign frame_done = en && (state == ST_CAPTURE) && (bitcnt == BC_W'(PAYLOAD_LEN - 1));

  seq_sync_matcher #(
    .SYNC_LEN (SYNC_LEN),
    .SYNC_PAT (SYNC_PAT)
  ) u_match (
    .clk   (clk),
    .reset (reset),
    .clear (frame_done),
    .en    (hunt_en),
    .Xin   (Xin),
    .match (match)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_HUNT;
    else       state <= state_nxt;
  end

  // Next-state: lock on sync, release after the last payload bit.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_HUNT:    if (match)      state_nxt = ST_CAPTURE;
      ST_CAPTURE: if (frame_done) state_nxt = ST_HUNT;
      default:                    state_nxt = ST_HUNT;
    endcase
  end

  // Outputs decoded from the registered state only.
  always_comb begin
    Locked = (state == ST_CAPTURE);
  end

  // Datapath: payload shifter, bit counter, pulses, output word, frame count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pay      <= '0;
      bitcnt   <= '0;
      Data     <= '0;
      Valid    <= 1'b0;
      SyncDet  <= 1'b0;
      FrameCnt <= '0;
    end else begin
      Valid   <= 1'b0;
      SyncDet <= 1'b0;
      if (match) begin
        SyncDet <= 1'b1;
        bitcnt  <= '0;
      end
      if (en && state == ST_CAPTURE) begin
        pay    <= PAYLOAD_LEN'({pay, Xin});
        bitcnt <= bitcnt + BC_W'(1);
        if (frame_done) begin
          Data  <= PAYLOAD_LEN'({pay, Xin});
          Valid <= 1'b1;
          if (~&FrameCnt)
            FrameCnt <= FrameCnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_frame_detector.sv
// Directed bench for seq_frame_detector; a second instance with a 2-bit
// frame counter covers saturation and back-to-back frames.
module tb_seq_frame_detector;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rst2 = 1'b1;
  logic       Xin = 1'b0;
  logic       en = 1'b0;
  logic [7:0] Data, Data_s;
  logic       Valid, SyncDet, Locked;
  logic       Valid_s, SyncDet_s, Locked_s;
  logic [7:0] FrameCnt;
  logic [1:0] FrameCnt_s;

  int ncheck = 0;
  int npass  = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_frame_detector dut (
    .clk(clk), .reset(reset), .Xin(Xin), .en(en),
    .Data(Data), .Valid(Valid), .SyncDet(SyncDet), .Locked(Locked), .FrameCnt(FrameCnt)
  );

  seq_frame_detector #(.CNT_W(2)) u_sat (
    .clk(clk), .reset(rst2), .Xin(Xin), .en(en),
    .Data(Data_s), .Valid(Valid_s), .SyncDet(SyncDet_s), .Locked(Locked_s), .FrameCnt(FrameCnt_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncheck++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Present one bit at the falling edge, then settle just past the rising edge.
  task automatic step(input logic x, input logic e);
    @(negedge clk);
    Xin = x;
    en  = e;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [11:0] fr;
    logic [13:0] fr3;
    int k;
    int last_v;
    int exp6 [5];
    fr   = 12'hBA5;                 // 1011 + 1010_0101
    fr3  = 14'b101011_10111011;     // overlapping sync + 8'hBB
    exp6 = '{1, 2, 3, 3, 3};

    // 1: reset held while stimulus toggles
    for (int i = 11; i >= 0; i--) begin
      step(fr[i], 1'b1);
      chk("t1_pulses", {Valid, SyncDet, Locked}, 3'b000);
      chk("t1_data", Data, 8'h00);
      chk("t1_cnt", FrameCnt, 8'h00);
    end
    @(negedge clk); reset = 1'b0;

    // 2: basic frame
    for (int i = 11; i >= 0; i--) begin
      step(fr[i], 1'b1);
      k = 12 - i;
      chk("t2_syncdet", SyncDet, k == 4);
      chk("t2_valid", Valid, k == 12);
      chk("t2_locked", Locked, k >= 4 && k < 12);
    end
    chk("t2_data", Data, 8'hA5);
    chk("t2_cnt", FrameCnt, 8'd1);
    step(1'b1, 1'b0);
    chk("t2_valid_drop", Valid, 1'b0);
    chk("t2_data_hold", Data, 8'hA5);

    // 3: sync found via overlap; sync-like payload not re-detected
    for (int i = 13; i >= 0; i--) begin
      step(fr3[i], 1'b1);
      k = 14 - i;
      chk("t3_syncdet", SyncDet, k == 6);
      chk("t3_valid", Valid, k == 14);
      chk("t3_locked", Locked, k >= 6 && k < 14);
    end
    chk("t3_data", Data, 8'hBB);
    chk("t3_cnt", FrameCnt, 8'd2);

    // 4: en every other cycle; idle cycles carry junk and never pulse
    for (int i = 11; i >= 0; i--) begin
      step(fr[i], 1'b1);
      k = 12 - i;
      chk("t4_syncdet", SyncDet, k == 4);
      chk("t4_valid", Valid, k == 12);
      step(~fr[i], 1'b0);
      chk("t4_idle_pulses", {Valid, SyncDet}, 2'b00);
      chk("t4_idle_locked", Locked, k >= 4 && k < 12);
    end
    chk("t4_data", Data, 8'hA5);
    chk("t4_cnt", FrameCnt, 8'd3);

    // 5: asynchronous reset mid-payload
    for (int i = 11; i >= 3; i--) step(fr[i], 1'b1);
    chk("t5_locked_pre", Locked, 1'b1);
    @(negedge clk); reset = 1'b1; #1;
    chk("t5_locked_rst", Locked, 1'b0);
    chk("t5_data_rst", Data, 8'h00);
    chk("t5_cnt_rst", FrameCnt, 8'h00);
    @(negedge clk); reset = 1'b0;
    for (int i = 11; i >= 0; i--) begin
      step(fr[i], 1'b1);
      chk("t5_valid", Valid, (12 - i) == 12);
    end
    chk("t5_data", Data, 8'hA5);
    chk("t5_cnt", FrameCnt, 8'd1);

    // 6: 2-bit counter saturates over five back-to-back frames
    @(negedge clk); rst2 = 1'b0;
    last_v = 0;
    for (int f = 0; f < 5; f++) begin
      for (int i = 11; i >= 0; i--) begin
        step(fr[i], 1'b1);
        k = 12 - i;
        chk("t6_valid", Valid_s, k == 12);
        chk("t6_syncdet", SyncDet_s, k == 4);
      end
      chk("t6_cnt", FrameCnt_s, exp6[f]);
      chk("t6_data", Data_s, 8'hA5);
      if (f > 0) chk("t6_period", cyc - last_v, 12);
      last_v = cyc;
    end
    chk("t6_main_cnt", FrameCnt, 8'd6);

    $display("%0d/%0d checks passed", npass, ncheck);
    $finish;
  end

endmodule
